// File: rtl/axis_frame_pkg.sv
// Shared definitions for the AXI-Stream frame packer: default widths and
// the framing FSM state encoding.
package axis_frame_pkg;

  localparam int unsigned AXIS_DATA_W  = 32;
  localparam int unsigned AXIS_TUSER_W = 1;
  localparam int unsigned FRAME_LEN_W  = 16;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } frame_state_e;

endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry skid buffer: an output register plus one overflow slot.
// in_ready is taken straight from a flop, so the upstream ready path is
// registered, and the output holds steady while out_ready is low.
//   aclk, areset          clock, synchronous active-high reset
//   in_data/valid/ready   upstream handshake (in_ready registered)
//   out_data/valid/ready  downstream handshake (out_* registered)
//   occupied              overflow slot holds a payload
module axis_skid_buffer #(
  parameter int unsigned PAYLOAD_W = 34
) (
  input  logic                 aclk,
  input  logic                 areset,
  input  logic [PAYLOAD_W-1:0] in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [PAYLOAD_W-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 occupied
);

  logic [PAYLOAD_W-1:0] skid_data_q;
  logic                 skid_valid_q;
  logic                 in_fire;

  assign in_ready = ~skid_valid_q;
  assign occupied = skid_valid_q;
  assign in_fire  = in_valid & ~skid_valid_q;

  // Output register loads whenever it is empty or being drained; otherwise
  // an incoming payload parks in the overflow slot.
  always_ff @(posedge aclk) begin
    if (areset) begin
      out_data     <= '0;
      out_valid    <= 1'b0;
      skid_data_q  <= '0;
      skid_valid_q <= 1'b0;
    end else if (out_ready || !out_valid) begin
      if (skid_valid_q) begin
        out_data     <= skid_data_q;
        out_valid    <= 1'b1;
        skid_valid_q <= 1'b0;
      end else begin
        out_valid <= in_fire;
        if (in_fire) out_data <= in_data;
      end
    end else if (in_fire) begin
      skid_data_q  <= in_data;
      skid_valid_q <= 1'b1;
    end
  end

endmodule

// File: rtl/axis_frame_packer.sv
// Cuts an unframed AXI-Stream sample stream into frames of frame_len beats,
// marking the first beat with tuser[0] and the last with tlast. A flush
// pulse ends the current frame early. Output is registered through a
// two-entry skid buffer.
//   m00_axis_aclk, m00_axis_areset  clock, synchronous active-high reset
//   enable                          permits a new frame to start
//   frame_len                       beats per frame, latched on first beat
//   flush                           pulse, terminates current frame early
//   s00_axis_*                      unframed input stream
//   m00_axis_*                      framed output stream
//   frame_count                     completed frames emitted (wraps)
//   busy                            frame in progress or output pending
module axis_frame_packer
  import axis_frame_pkg::*;
#(
  parameter int unsigned C_AXIS_TDATA_WIDTH = AXIS_DATA_W,
  parameter int unsigned TUSER_WIDTH        = AXIS_TUSER_W,
  parameter int unsigned LEN_WIDTH          = FRAME_LEN_W
) (
  input  logic                            m00_axis_aclk,
  input  logic                            m00_axis_areset,
  input  logic                            enable,
  input  logic [LEN_WIDTH-1:0]            frame_len,
  input  logic                            flush,
  input  logic [C_AXIS_TDATA_WIDTH-1:0]   s00_axis_tdata,
  input  logic                            s00_axis_tvalid,
  output logic                            s00_axis_tready,
  output logic [C_AXIS_TDATA_WIDTH-1:0]   m00_axis_tdata,
  output logic [C_AXIS_TDATA_WIDTH/8-1:0] m00_axis_tstrb,
  output logic                            m00_axis_tvalid,
  input  logic                            m00_axis_tready,
  output logic                            m00_axis_tlast,
  output logic [TUSER_WIDTH-1:0]          m00_axis_tuser,
  output logic [31:0]                     frame_count,
  output logic                            busy
);

  localparam int unsigned PAYLOAD_W = C_AXIS_TDATA_WIDTH + 1 + TUSER_WIDTH;

  frame_state_e         state_q, state_d;
  logic [LEN_WIDTH-1:0] cnt_q, cnt_d;
  logic [LEN_WIDTH-1:0] len_q, len_d;
  logic                 flush_pend_q, flush_pend_d;

  logic                 accept;
  logic                 first_beat;
  logic                 is_last;
  logic [LEN_WIDTH-1:0] eff_len;
  logic [LEN_WIDTH-1:0] beat_idx;
  logic                 skid_ready;
  logic                 skid_occupied;
  logic [PAYLOAD_W-1:0] in_payload;
  logic [PAYLOAD_W-1:0] out_payload;

  // Registered skid-slot ready, gated by reset and by whether a frame may run.
  assign s00_axis_tready = ~m00_axis_areset & skid_ready &
                           ((state_q == ST_ACTIVE) | enable);
  assign accept = s00_axis_tvalid & s00_axis_tready;

  // State register.
  always_ff @(posedge m00_axis_aclk) begin
    if (m00_axis_areset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      len_q        <= '0;
      flush_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      len_q        <= len_d;
      flush_pend_q <= flush_pend_d;
    end
  end

  // Next-state and beat classification. In IDLE the incoming beat opens a
  // frame, so the live frame_len (0 read as 1) and index 0 apply to it.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    len_d        = len_q;
    flush_pend_d = flush_pend_q;

    first_beat = (state_q == ST_IDLE);
    if (first_beat) begin
      eff_len  = (frame_len == '0) ? LEN_WIDTH'(1) : frame_len;
      beat_idx = '0;
    end else begin
      eff_len  = len_q;
      beat_idx = cnt_q;
    end
    is_last = (beat_idx == eff_len - LEN_WIDTH'(1)) | flush | flush_pend_q;

    if (accept) begin
      len_d        = eff_len;
      cnt_d        = is_last ? '0 : beat_idx + LEN_WIDTH'(1);
      flush_pend_d = 1'b0;
      if (first_beat && !is_last) state_d = ST_ACTIVE;
      else if (!first_beat && is_last) state_d = ST_IDLE;
    end else if (flush && !first_beat) begin
      flush_pend_d = 1'b1;
    end
  end

  assign in_payload = {TUSER_WIDTH'(first_beat), is_last, s00_axis_tdata};

  axis_skid_buffer #(
    .PAYLOAD_W (PAYLOAD_W)
  ) u_skid (
    .aclk      (m00_axis_aclk),
    .areset    (m00_axis_areset),
    .in_data   (in_payload),
    .in_valid  (accept),
    .in_ready  (skid_ready),
    .out_data  (out_payload),
    .out_valid (m00_axis_tvalid),
    .out_ready (m00_axis_tready),
    .occupied  (skid_occupied)
  );

  assign m00_axis_tdata = out_payload[C_AXIS_TDATA_WIDTH-1:0];
  assign m00_axis_tlast = out_payload[C_AXIS_TDATA_WIDTH];
  assign m00_axis_tuser = out_payload[C_AXIS_TDATA_WIDTH+1 +: TUSER_WIDTH];
  assign m00_axis_tstrb = {(C_AXIS_TDATA_WIDTH/8){m00_axis_tvalid}};

  // Completed-frame counter, bumped on each output handshake carrying tlast.
  always_ff @(posedge m00_axis_aclk) begin
    if (m00_axis_areset) begin
      frame_count <= '0;
    end else if (m00_axis_tvalid && m00_axis_tready && m00_axis_tlast) begin
      frame_count <= frame_count + 32'd1;
    end
  end

  assign busy = (state_q == ST_ACTIVE) | m00_axis_tvalid | skid_occupied;

endmodule

// File: doc/axis_frame_packer.md
AXIS_FRAME_PACKER -- requirements
Module: axis_frame_packer

Interface
REQ-001 SHALL have parameter C_AXIS_TDATA_WIDTH, default 32: data width in bits, a multiple of 8.
REQ-002 SHALL have parameter TUSER_WIDTH, default 1: width of m00_axis_tuser; bit 0 marks start of frame.
REQ-003 SHALL have parameter LEN_WIDTH, default 16: width of frame_len and of the beat counter.
REQ-004 SHALL use one clock and a synchronous, active-high reset; the ports are as follows.
REQ-005 m00_axis_aclk  in  1  sole clock; all state updates on the rising edge.
REQ-006 m00_axis_areset  in  1  reset, synchronous, active-high.
REQ-007 enable  in  1  permits a new frame to start.
REQ-008 frame_len  in  LEN_WIDTH  beats per frame; latched on the first beat.
REQ-009 flush  in  1  pulse; terminates the current frame early.
REQ-010 s00_axis_tdata / s00_axis_tvalid / s00_axis_tready  in/in/out  C_AXIS_TDATA_WIDTH/1/1  unframed sample stream.
REQ-011 m00_axis_tdata / tstrb / tvalid / tready / tlast / tuser  out/out/out/in/out/out  C_AXIS_TDATA_WIDTH/C_AXIS_TDATA_WIDTH/8/1/1/1/TUSER_WIDTH  framed stream that feeds the async FIFO.
REQ-012 frame_count  out  32  number of completed frames emitted.
REQ-013 busy  out  1  a frame is in progress or output data is pending.

Function
REQ-014 SHALL implement an FSM with states IDLE and ACTIVE.
  - IDLE -> ACTIVE on an accepted input beat that is not a last beat.
  - ACTIVE -> IDLE on an accepted last beat.
REQ-015 An input beat is accepted when s00_axis_tvalid && s00_axis_tready.
REQ-016 s00_axis_tready SHALL be 1 when all three hold: not in reset, the skid buffer is empty, and (state == ACTIVE or enable == 1).
REQ-017 In IDLE with enable == 0, the block SHALL accept no beats.
REQ-018 Deasserting enable in ACTIVE SHALL NOT stop the current frame; the frame completes normally.
REQ-019 On the first beat of a frame, the block SHALL latch frame_len; frame_len == 0 is treated as 1.
REQ-020 Changes to frame_len mid-frame SHALL be ignored.
REQ-021 The beat counter SHALL reset to 0 at each frame start and increment per accepted beat.
REQ-022 A beat SHALL be the last beat (tlast = 1) when either:
  - beat index == latched length - 1, or
  - flush is asserted in the same cycle as the beat, or
  - flush_pending is set.
REQ-023 A flush asserted with no accepted beat, while in ACTIVE, SHALL set flush_pending.
  - flush_pending clears on the next accepted beat.
  - A flush in IDLE with no beat SHALL be ignored.
REQ-024 The first beat of each frame SHALL carry tuser[0] = 1; all other tuser bits, and tuser[0] on later beats, SHALL be 0.
REQ-025 A single-beat frame SHALL carry tuser[0] = 1 and tlast = 1 together.
REQ-026 m00_axis_tstrb SHALL be all ones on every valid beat.
REQ-027 Output SHALL be registered, with a latency of 1 cycle from input acceptance to m00_axis_tvalid when the output is not stalled.
REQ-028 A 2-entry skid buffer SHALL hold data under backpressure so that s00_axis_tready is a registered signal.
REQ-029 Throughput SHALL be 1 beat/cycle sustained while m00_axis_tready == 1.
REQ-030 Once m00_axis_tvalid is asserted, m00_axis_tdata, tlast and tuser SHALL stay stable until m00_axis_tready == 1.
REQ-031 frame_count SHALL increment on each output handshake with tlast = 1, wrapping modulo 2^32.
REQ-032 busy SHALL equal (state == ACTIVE) || m00_axis_tvalid || skid buffer occupied.

Reset
REQ-033 While m00_axis_areset == 1, all of the following SHALL hold:
  - state = IDLE;
  - beat counter, flush_pending, frame_count = 0;
  - m00_axis_tvalid = 0, s00_axis_tready = 0, busy = 0;
  - skid buffer empty; tdata/tlast/tuser = 0.
REQ-034 A reset asserted mid-frame SHALL discard the partial frame without emitting tlast; the first accepted beat after reset starts a new frame.

Structure
REQ-035 A shared package axis_frame_pkg SHALL hold the FSM state encoding and the default widths (data, tuser, length).
REQ-036 The skid buffer SHALL be a sub-module, axis_skid_buffer, parameterised by payload width (data + tlast + tuser).

Verification
REQ-037 Case 1 -> frame_len = 4, enable = 1, 12 contiguous beats with data 0..11, tready = 1: three frames come out.
  - tuser[0] = 1 on data 0, 4, 8; tlast = 1 on data 3, 7, 11.
  - frame_count = 3; latency 1 cycle.
REQ-038 Case 2 -> frame_len = 1: every output beat has tuser[0] = 1 and tlast = 1; after 5 beats, frame_count = 5.
REQ-039 Case 3 -> frame_len = 8; flush pulses alone after beat 2; beats 3..5 follow.
  - Beat 3 carries tlast; beat 4 starts a new frame with tuser[0] = 1.
REQ-040 Case 4 -> frame_len = 4; m00_axis_tready toggles with a 1-cycle on / 2-cycle off pattern for 16 beats.
  - No beat is lost or duplicated, data order is preserved, and held output signals stay stable while stalled.
REQ-041 Case 5 -> enable is dropped after beat 1 of a 4-beat frame.
  - Beats 2 and 3 are still accepted and beat 3 carries tlast.
  - Afterwards s00_axis_tready = 0 and busy returns to 0.
REQ-042 Case 6 -> reset is asserted for 1 cycle after beat 2 of a frame_len = 6 frame.
  - Outputs go to their reset values with no tlast emitted.
  - The next beat has tuser[0] = 1, and frame_count stays 0 until a full frame completes.
